id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection.
//  Captures decoded operands, register specifiers and control from ID each cycle.
//  Its IDEXRs/IDEXRt/IDEXRd/IDEXCtrl outputs feed the forwarding unit and the EX stage.
//  Inserts bubbles on a load-use hazard or a branch flush, holds on a global hold, and counts bubbles.
// PARAMETERS
//  DATA_W  32  width of operand and immediate datapaths
//  REG_W   5   register specifier width
//  CNT_W   16  width of the saturating bubble counter
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  IFIDRs         in   REG_W   Rs of the instruction in ID
//  IFIDRt         in   REG_W   Rt of the instruction in ID
//  IFIDRd         in   REG_W   Rd of the instruction in ID
//  IFIDUsesRt     in   1       ID instruction reads Rt as a source (R-type, store, branch)
//  IFIDValid      in   1       ID holds a real instruction
//  IDReadData1    in   DATA_W  register file port 1
//  IDReadData2    in   DATA_W  register file port 2
//  IDImm          in   DATA_W  sign-extended immediate
//  IDCtrl         in   8       [0]RegWrite [1]MemtoReg [2]MemRead [3]MemWrite [4]RegDst [5]ALUSrc [7:6]ALUOp
//  flush          in   1       branch taken in EX; kill the ID instruction
//  hold           in   1       global freeze (memory wait)
//  IDEXRs         out  REG_W   registered Rs
//  IDEXRt         out  REG_W   registered Rt
//  IDEXRd         out  REG_W   registered Rd
//  IDEXReadData1  out  DATA_W  registered operand 1
//  IDEXReadData2  out  DATA_W  registered operand 2
//  IDEXImm        out  DATA_W  registered immediate
//  IDEXCtrl       out  8       registered control
//  IDEXValid      out  1       EX holds a real instruction
//  stall          out  1       deasserts PCWrite/IFIDWrite upstream (combinational)
//  bubbleCount    out  CNT_W   saturating count of load-use bubbles
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; stall=0 while in reset; the counter clears immediately.
//  loadUse = IDEXValid & IDEXCtrl[2] & IFIDValid & (IDEXRt!=0)
//            & ((IDEXRt==IFIDRs) | (IFIDUsesRt & (IDEXRt==IFIDRt))).
//  stall = loadUse & ~flush & ~hold. Derived only from registered state and inputs; no extra latency.
//  Per rising edge, priority is highest first:
//   1 flush: bubble. IDEXCtrl=0, IDEXValid=0, Rs/Rt/Rd=0, data fields=0.
//   2 hold: every register keeps its value; bubbleCount unchanged.
//   3 loadUse: bubble, as in 1. bubbleCount += 1, saturating at all-ones.
//   4 otherwise: capture all ID inputs. IDEXValid=IFIDValid; IDEXCtrl = IFIDValid ? IDCtrl : 0.
//  Capture latency is 1 cycle: ID values appear on IDEX* after the next edge.
//  A load-use hazard produces exactly one bubble. The next cycle, EX holds the bubble,
//   so loadUse=0 and the held ID instruction advances.
//  A bubble zeroes the specifiers, so the forwarding unit sees no match on a bubble.
//  flush and loadUse together: flush wins, stall=0, counter not incremented.
//  hold and loadUse together: nothing moves, stall=0 (the global hold already freezes upstream).
//   The stall is evaluated again once hold drops.
//  Register $0 as the load target never stalls.
// TESTING
//  lw $8 then add $9,$8,$3 (IFIDRs=8): stall=1 for exactly 1 cycle; next IDEXCtrl=0, IDEXValid=0;
//   bubbleCount 0->1; add enters EX the following cycle.
//  lw $8 then sw $8 (Rt=8, IFIDUsesRt=1): 1-cycle stall. Same Rt with IFIDUsesRt=0: no stall.
//  lw $0 then add $9,$0,$0: stall=0 and bubbleCount unchanged.
//  loadUse and flush in the same cycle: stall=0, bubble inserted, bubbleCount unchanged.
//  hold=1 for 3 cycles with loadUse pending: IDEX* frozen and stall=0.
//   After hold drops: one stall cycle, then normal flow.
//  Preload bubbleCount to 0xFFFF and trigger a load-use: it stays 0xFFFF.
//   Assert rst_n=0 mid-stall: all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID/EX pipeline register with load-use hazard detection built in.
//   Each cycle it captures the decoded operands, register specifiers and
//   control of the instruction in ID. On a load-use hazard or a branch flush
//   it inserts a bubble instead. It freezes on a global hold. It also keeps
//   a saturating count of load-use bubbles.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   IFIDRs/IFIDRt/IFIDRd       register specifiers of the instruction in ID
//   IFIDUsesRt                 ID instruction reads Rt as a source
//   IFIDValid                  ID holds a real instruction
//   IDReadData1/2, IDImm       operands and sign-extended immediate from ID
//   IDCtrl                     [0]RegWrite [1]MemtoReg [2]MemRead [3]MemWrite
//                              [4]RegDst [5]ALUSrc [7:6]ALUOp
//   flush                      kill the ID instruction (branch taken in EX)
//   hold                       global freeze
//   IDEX*                      registered copies feeding EX and forwarding
//   IDEXValid                  EX holds a real instruction
//   stall                      combinational PCWrite/IFIDWrite inhibit
//   bubbleCount                saturating count of load-use bubbles
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  IFIDRs,
  input  logic [REG_W-1:0]  IFIDRt,
  input  logic [REG_W-1:0]  IFIDRd,
  input  logic              IFIDUsesRt,
  input  logic              IFIDValid,
  input  logic [DATA_W-1:0] IDReadData1,
  input  logic [DATA_W-1:0] IDReadData2,
  input  logic [DATA_W-1:0] IDImm,
  input  logic [7:0]        IDCtrl,
  input  logic              flush,
  input  logic              hold,
  output logic [REG_W-1:0]  IDEXRs,
  output logic [REG_W-1:0]  IDEXRt,
  output logic [REG_W-1:0]  IDEXRd,
  output logic [DATA_W-1:0] IDEXReadData1,
  output logic [DATA_W-1:0] IDEXReadData2,
  output logic [DATA_W-1:0] IDEXImm,
  output logic [7:0]        IDEXCtrl,
  output logic              IDEXValid,
  output logic              stall,
  output logic [CNT_W-1:0]  bubbleCount
);

  logic [REG_W-1:0]  rs_p1, rt_p1, rd_p1;
  logic [DATA_W-1:0] rd1_p1, rd2_p1, imm_p1;
  logic [7:0]        ctrl_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic              load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A real load in EX whose nonzero target is read by a real instruction in ID.
  // Rt only matters when the ID instruction actually sources it.
  assign load_use = vld_p1 & ctrl_p1[2] & IFIDValid & (rt_p1 != '0)
                  & ((rt_p1 == IFIDRs) | (IFIDUsesRt & (rt_p1 == IFIDRt)));

  // flush kills the ID instruction anyway, and hold already freezes upstream.
  assign stall = load_use & ~flush & ~hold;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_p1   <= '0;
      rt_p1   <= '0;
      rd_p1   <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      imm_p1  <= '0;
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (flush || (!hold && load_use)) begin
      // Bubble: specifiers are zeroed too so forwarding never matches it.
      rs_p1   <= '0;
      rt_p1   <= '0;
      rd_p1   <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      imm_p1  <= '0;
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
      if (!flush) cnt_p1 <= sat_inc(cnt_p1);
    end else if (!hold) begin
      rs_p1   <= IFIDRs;
      rt_p1   <= IFIDRt;
      rd_p1   <= IFIDRd;
      rd1_p1  <= IDReadData1;
      rd2_p1  <= IDReadData2;
      imm_p1  <= IDImm;
      ctrl_p1 <= IFIDValid ? IDCtrl : 8'h00;
      vld_p1  <= IFIDValid;
    end
  end

  assign IDEXRs        = rs_p1;
  assign IDEXRt        = rt_p1;
  assign IDEXRd        = rd_p1;
  assign IDEXReadData1 = rd1_p1;
  assign IDEXReadData2 = rd2_p1;
  assign IDEXImm       = imm_p1;
  assign IDEXCtrl      = ctrl_p1;
  assign IDEXValid     = vld_p1;
  assign bubbleCount   = cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;
  localparam logic [7:0] C_LW  = 8'h27;
  localparam logic [7:0] C_ADD = 8'h91;
  localparam logic [7:0] C_SW  = 8'h28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [REG_W-1:0]  IFIDRs = '0, IFIDRt = '0, IFIDRd = '0;
  logic              IFIDUsesRt = 1'b0, IFIDValid = 1'b0;
  logic [DATA_W-1:0] IDReadData1 = '0, IDReadData2 = '0, IDImm = '0;
  logic [7:0]        IDCtrl = '0;
  logic              flush = 1'b0, hold = 1'b0;

  logic [REG_W-1:0]  IDEXRs, IDEXRt, IDEXRd;
  logic [DATA_W-1:0] IDEXReadData1, IDEXReadData2, IDEXImm;
  logic [7:0]        IDEXCtrl;
  logic              IDEXValid, stall;
  logic [CNT_W-1:0]  bubbleCount;

  logic [REG_W-1:0]  s_Rs, s_Rt, s_Rd;
  logic [DATA_W-1:0] s_D1, s_D2, s_Imm;
  logic [7:0]        s_Ctrl;
  logic              s_Valid, s_stall;
  logic [SAT_W-1:0]  s_cnt;

  int checks = 0;
  int failures = 0;
  int seq = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDRd(IFIDRd),
    .IFIDUsesRt(IFIDUsesRt), .IFIDValid(IFIDValid), .IDReadData1(IDReadData1),
    .IDReadData2(IDReadData2), .IDImm(IDImm), .IDCtrl(IDCtrl), .flush(flush),
    .hold(hold), .IDEXRs(IDEXRs), .IDEXRt(IDEXRt), .IDEXRd(IDEXRd),
    .IDEXReadData1(IDEXReadData1), .IDEXReadData2(IDEXReadData2), .IDEXImm(IDEXImm),
    .IDEXCtrl(IDEXCtrl), .IDEXValid(IDEXValid), .stall(stall), .bubbleCount(bubbleCount));

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IFIDRd(IFIDRd),
    .IFIDUsesRt(IFIDUsesRt), .IFIDValid(IFIDValid), .IDReadData1(IDReadData1),
    .IDReadData2(IDReadData2), .IDImm(IDImm), .IDCtrl(IDCtrl), .flush(flush),
    .hold(hold), .IDEXRs(s_Rs), .IDEXRt(s_Rt), .IDEXRd(s_Rd),
    .IDEXReadData1(s_D1), .IDEXReadData2(s_D2), .IDEXImm(s_Imm),
    .IDEXCtrl(s_Ctrl), .IDEXValid(s_Valid), .stall(s_stall), .bubbleCount(s_cnt));

  // Model: what EX should hold, plus an unbounded bubble tally.
  logic [REG_W-1:0]  m_rs = '0, m_rt = '0, m_rd = '0;
  logic [DATA_W-1:0] m_d1 = '0, m_d2 = '0, m_imm = '0;
  logic [7:0]        m_ctrl = '0;
  logic              m_vld = 1'b0;
  int                m_cnt = 0;

  function automatic logic hazard();
    logic ex_is_load;
    logic id_reads;
    ex_is_load = m_vld && m_ctrl[2] && (m_rt != 0);
    id_reads   = (m_rt == IFIDRs) || (IFIDUsesRt && (m_rt == IFIDRt));
    return ex_is_load && IFIDValid && id_reads;
  endfunction

  function automatic longint capped(input int n, input longint lim);
    return (n > lim) ? lim : longint'(n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rs <= '0; m_rt <= '0; m_rd <= '0; m_d1 <= '0; m_d2 <= '0; m_imm <= '0;
      m_ctrl <= '0; m_vld <= 1'b0; m_cnt <= 0;
    end else if (flush || (!hold && hazard())) begin
      m_rs <= '0; m_rt <= '0; m_rd <= '0; m_d1 <= '0; m_d2 <= '0; m_imm <= '0;
      m_ctrl <= '0; m_vld <= 1'b0;
      if (!flush) m_cnt <= m_cnt + 1;
    end else if (!hold) begin
      m_rs <= IFIDRs; m_rt <= IFIDRt; m_rd <= IFIDRd;
      m_d1 <= IDReadData1; m_d2 <= IDReadData2; m_imm <= IDImm;
      m_ctrl <= IFIDValid ? IDCtrl : 8'h00;
      m_vld <= IFIDValid;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag,
                         input logic [REG_W-1:0] rs, rt, rd,
                         input logic [DATA_W-1:0] d1, d2, imm,
                         input logic [7:0] ctrl, input logic vld, st,
                         input logic [63:0] cnt, input logic [63:0] exp_cnt,
                         input logic exp_st);
    chk({tag, ".Rs"}, rs, m_rs);
    chk({tag, ".Rt"}, rt, m_rt);
    chk({tag, ".Rd"}, rd, m_rd);
    chk({tag, ".D1"}, d1, m_d1);
    chk({tag, ".D2"}, d2, m_d2);
    chk({tag, ".Imm"}, imm, m_imm);
    chk({tag, ".Ctrl"}, ctrl, m_ctrl);
    chk({tag, ".Valid"}, vld, m_vld);
    chk({tag, ".stall"}, st, exp_st);
    chk({tag, ".count"}, cnt, exp_cnt);
  endtask

  always @(negedge clk) begin
    logic exp_st;
    exp_st = rst_n && hazard() && !flush && !hold;
    cmp_all("dut", IDEXRs, IDEXRt, IDEXRd, IDEXReadData1, IDEXReadData2, IDEXImm,
            IDEXCtrl, IDEXValid, stall, bubbleCount, capped(m_cnt, 65535), exp_st);
    cmp_all("sat", s_Rs, s_Rt, s_Rd, s_D1, s_D2, s_Imm,
            s_Ctrl, s_Valid, s_stall, s_cnt, capped(m_cnt, 7), exp_st);
  end

  task automatic apply(input logic [REG_W-1:0] rs, rt, rd, input logic ut, v,
                       input logic [7:0] c, input logic fl, hd);
    seq++;
    IFIDRs = rs; IFIDRt = rt; IFIDRd = rd; IFIDUsesRt = ut; IFIDValid = v;
    IDCtrl = c; flush = fl; hold = hd;
    IDReadData1 = 32'h1000_0000 + seq;
    IDReadData2 = 32'h2000_0000 + seq;
    IDImm = 32'hFFFF_FF00 + seq;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    apply(0, 0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    #1;
    chk("reset.Valid", IDEXValid, 0);
    chk("reset.Ctrl", IDEXCtrl, 0);
    chk("reset.stall", stall, 0);
    chk("reset.count", bubbleCount, 0);
    tick(); tick();
    rst_n = 1'b1;

    // lw $8 ; add $9,$8,$3
    apply(2, 8, 0, 0, 1, C_LW, 0, 0); chk("lw.stall_none", stall, 0); tick();
    apply(8, 3, 9, 1, 1, C_ADD, 0, 0);
    chk("lwadd.exctrl", IDEXCtrl, C_LW);
    chk("lwadd.stall", stall, 1);
    tick();
    apply(8, 3, 9, 1, 1, C_ADD, 0, 0);
    chk("lwadd.bubble_stall", stall, 0);
    chk("lwadd.bubble_valid", IDEXValid, 0);
    chk("lwadd.bubble_ctrl", IDEXCtrl, 0);
    chk("lwadd.bubble_rt", IDEXRt, 0);
    chk("lwadd.count", bubbleCount, 1);
    tick();
    nop();
    chk("lwadd.add_ctrl", IDEXCtrl, C_ADD);
    chk("lwadd.add_rd", IDEXRd, 9);
    chk("lwadd.add_valid", IDEXValid, 1);
    tick();

    // lw $8 ; sw $8 (Rt used) then same Rt not used
    apply(2, 8, 0, 0, 1, C_LW, 0, 0); tick();
    apply(4, 8, 0, 1, 1, C_SW, 0, 0); chk("lwsw.stall", stall, 1); tick();
    apply(4, 8, 0, 1, 1, C_SW, 0, 0); chk("lwsw.after", stall, 0); tick();
    apply(2, 8, 0, 0, 1, C_LW, 0, 0); tick();
    apply(4, 8, 0, 0, 1, C_LW, 0, 0); chk("rt_unused.stall", stall, 0); tick();
    nop(); chk("rt_unused.count", bubbleCount, 2); tick();

    // lw $0 ; add $9,$0,$0
    apply(2, 0, 0, 0, 1, C_LW, 0, 0); tick();
    apply(0, 0, 9, 1, 1, C_ADD, 0, 0); chk("r0.stall", stall, 0); tick();
    nop(); chk("r0.count", bubbleCount, 2); tick();

    // load-use together with flush
    apply(2, 8, 0, 0, 1, C_LW, 0, 0); tick();
    apply(8, 3, 9, 1, 1, C_ADD, 1, 0); chk("flush.stall", stall, 0); tick();
    nop();
    chk("flush.valid", IDEXValid, 0);
    chk("flush.count", bubbleCount, 2);
    tick();

    // hold for 3 cycles with load-use pending
    apply(2, 8, 0, 0, 1, C_LW, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(8, 3, 9, 1, 1, C_ADD, 0, 1);
      chk("hold.stall", stall, 0);
      chk("hold.ctrl", IDEXCtrl, C_LW);
      chk("hold.rt", IDEXRt, 8);
      tick();
    end
    apply(8, 3, 9, 1, 1, C_ADD, 0, 0); chk("hold.release_stall", stall, 1); tick();
    apply(8, 3, 9, 1, 1, C_ADD, 0, 0);
    chk("hold.release_after", stall, 0);
    chk("hold.count", bubbleCount, 3);
    tick();

    // repeated load-use to drive the narrow counter into saturation
    for (int i = 0; i < 8; i++) begin
      apply(2, 8, 0, 0, 1, C_LW, 0, 0); tick();
      apply(8, 3, 9, 1, 1, C_ADD, 0, 0); tick();
      apply(8, 3, 9, 1, 1, C_ADD, 0, 0); tick();
    end
    nop();
    chk("sat.main_count", bubbleCount, 11);
    chk("sat.narrow_count", s_cnt, 7);
    tick();

    // async reset in the middle of a stall
    apply(2, 8, 0, 0, 1, C_LW, 0, 0); tick();
    apply(8, 3, 9, 1, 1, C_ADD, 0, 0); chk("arst.pre_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("arst.stall", stall, 0);
    chk("arst.valid", IDEXValid, 0);
    chk("arst.ctrl", IDEXCtrl, 0);
    chk("arst.rt", IDEXRt, 0);
    chk("arst.d1", IDEXReadData1, 0);
    chk("arst.count", bubbleCount, 0);
    tick();
    rst_n = 1'b1;
    nop(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
